score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Converts a signed score into six active-low seven-segment patterns (5 digits + minus sign).
//  Uses a serial double-dabble converter and a frame-synchronous commit.
//  Sits between game logic and the VGA seven-segment renderer (seg7_dig0..4, seg7_neg_sign).
//  Outputs change only on a frame boundary, so no partially updated digits are ever drawn.
// PARAMETERS
//  VALUE_W        18       signed input width (two's complement)
//  SAT_MAX        99999    magnitude clamp; larger magnitudes display SAT_MAX
//  BLANK_LEADING  1        1: blank leading zeros (dig0 always shown); 0: show all 5 digits
// PORTS
//  clk            in   1        system/pixel clock; all logic on rising edge
//  resetn         in   1        asynchronous, active-low reset
//  value          in   VALUE_W  signed score; sampled only on accept
//  update_req     in   1        level request; held until update_ack is seen
//  update_ack     out  1        one-cycle pulse: value accepted
//  frame_start    in   1        one-cycle pulse at start of vertical blanking
//  busy           out  1        high from accept until commit
//  overflow       out  1        committed value was clamped to SAT_MAX
//  seg7_dig0..4   out  7 each   active-low glyphs, bit0=a .. bit6=g; dig0 = ones digit
//  seg7_neg_sign  out  7        7'h3F (g lit) if negative, else 7'h7F
// BEHAVIOUR
//  Reset (async, immediate): dig0 = 7'h40 ('0'); dig1..4 and neg_sign = 7'h7F.
//   update_ack, busy and overflow = 0; FSM = IDLE; any in-flight conversion is discarded.
//  FSM: IDLE -> CONVERT -> ENCODE -> WAIT_FRAME -> IDLE.
//  IDLE: if update_req is high at cycle T, then in that cycle:
//   - update_ack = 1 and value is latched;
//   - sign = value[MSB], mag = |value|;
//   - if mag > SAT_MAX, mag = SAT_MAX and clamp flag = 1;
//   - busy rises at T+1.
//   |value| is computed at VALUE_W+1 bits, so the most negative input clamps correctly.
//  CONVERT: 17 cycles (T+1..T+17), one double-dabble shift per cycle.
//   Each shift adds 3 to any BCD nibble >= 5; 17-bit mag into a 20-bit BCD register (5 nibbles).
//  ENCODE: 1 cycle (T+18).
//   - BCD -> glyph into shadow registers.
//   - Digits above the highest nonzero digit are 7'h7F when BLANK_LEADING = 1.
//   - neg shadow = 7'h3F iff sign = 1 (mag is never 0 when sign = 1).
//  WAIT_FRAME: entered at T+19. frame_start is sampled from T+19 onward.
//   The first edge with frame_start = 1 copies shadow -> outputs and clamp flag -> overflow.
//   busy = 0 and FSM = IDLE after that edge.
//  Minimum accept-to-display latency is 20 cycles; typical latency is up to 1 frame.
//  Boundaries:
//   - update_req while busy: ignored, no ack; accepted in IDLE after commit.
//   - Earliest re-accept is the cycle after commit.
//   - frame_start outside WAIT_FRAME: ignored (no commit, no queuing).
//   - update_req held continuously: one accept per commit cycle; value is re-sampled each time.
//   - Outputs hold their last committed value indefinitely between commits.
//   - resetn asserted in any state: reset values on the same edge, no ack.
// STRUCTURE
//  Shared package score_disp_pkg:
//   - FSM state encoding;
//   - SEG_BLANK = 7'h7F, SEG_MINUS = 7'h3F;
//   - glyph constants 0-9: 40,79,24,30,19,12,02,78,00,10 (hex);
//   - function bcd_to_seg7.
//  Sub-module bin2bcd_serial: start/done handshake; 17-bit binary in, 20-bit BCD out, 17 cycles.
//  Top-level holds FSM, abs/clamp, blanking, shadow and output registers.
// TESTING
//  1 Reset, no stimulus -> dig0 = 40, dig1..4 = 7F, neg = 7F, busy = 0, overflow = 0.
//  2 value = 12345, req at T, frame_start at T+30 -> ack at T only; outputs unchanged until T+30.
//    Then dig4..0 = 79,24,30,19,12; neg = 7F; busy = 0 at T+31.
//  3 value = -42 -> dig1 = 19, dig0 = 24, dig2..4 = 7F, neg = 3F.
//    With BLANK_LEADING = 0: dig2..4 = 40.
//  4 value = 250000 -> dig0..4 = 10, overflow = 1.
//    Then value = -131072 -> 99999 with neg = 3F, overflow = 1.
//    Then value = 7 -> dig0 = 78, overflow = 0.
//  5 req pulsed during CONVERT -> no ack; frame_start pulse at T+5 -> ignored, commit waits for next pulse.
//    frame_start at exactly T+19 -> commits at T+19.
//  6 resetn low during WAIT_FRAME holding 54321 -> reset values immediately, 54321 never displayed.
//    value = 0 after reset -> dig0 = 40, rest 7F.

Source files
------------

// File: rtl/score_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_disp_pkg
// Description : Shared types, glyph constants and BCD-to-segment helper for
//               the score display controller.
// Revision    : 1.0 - initial release
// ============================================================================
package score_disp_pkg;

  // Converter geometry: 17-bit magnitude, five BCD nibbles.
  localparam int MAG_W      = 17;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONVERT    = 2'd1,
    ST_ENCODE     = 2'd2,
    ST_WAIT_FRAME = 2'd3
  } state_e;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Non-decimal nibbles cannot come out of the converter; show blank if they do.
  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_serial
// Description : Serial double-dabble converter. One shift per cycle; a start
//               pulse loads the operand, done is high during the final shift
//               so the BCD result is stable from the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_serial
  import score_disp_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [MAG_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Add-3 correction on each nibble, then shift the next binary bit in.
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(MAG_W);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[BCD_W-2:0], bin_q[MAG_W-1]};
      bin_d = {bin_q[MAG_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Converter state registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_display_ctrl
// Description : Signed score to six active-low seven-segment glyphs (five
//               digits plus minus sign). Results are staged in shadow
//               registers and committed only on a frame_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int VALUE_W       = 18,
  parameter int SAT_MAX       = 99999,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [VALUE_W-1:0] value,
  input  logic               update_req,
  output logic               update_ack,
  input  logic               frame_start,
  output logic               busy,
  output logic               overflow,
  output logic [6:0]         seg7_dig0,
  output logic [6:0]         seg7_dig1,
  output logic [6:0]         seg7_dig2,
  output logic [6:0]         seg7_dig3,
  output logic [6:0]         seg7_dig4,
  output logic [6:0]         seg7_neg_sign
);

  state_e state_q, state_d;
  logic   sign_q, sign_d;
  logic   clamp_q, clamp_d;
  logic   ovf_q, ovf_d;
  logic [BCD_DIGITS-1:0][6:0] shadow_q, shadow_d;
  logic [BCD_DIGITS-1:0][6:0] dig_q, dig_d;
  logic [6:0] shadow_neg_q, shadow_neg_d;
  logic [6:0] neg_q, neg_d;

  logic [VALUE_W:0]           val_ext, val_abs;
  logic                       over_sat;
  logic [MAG_W-1:0]           mag;
  logic                       conv_start, conv_done;
  logic [BCD_W-1:0]           conv_bcd;
  logic [BCD_DIGITS-1:0][6:0] glyph;
  logic [3:0]                 nib;
  logic                       seen;

  // Magnitude at VALUE_W+1 bits so the most negative input survives negation.
  always_comb begin
    val_ext  = {value[VALUE_W-1], value};
    val_abs  = value[VALUE_W-1] ? (~val_ext + (VALUE_W+1)'(1)) : val_ext;
    over_sat = (32'(val_abs) > 32'(SAT_MAX));
    mag      = over_sat ? MAG_W'(SAT_MAX) : MAG_W'(val_abs);
  end

  bin2bcd_serial u_bin2bcd (
    .clk    (clk),
    .resetn (resetn),
    .start  (conv_start),
    .bin    (mag),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Glyph lookup with leading-zero blanking scanned from the top digit down.
  always_comb begin
    glyph = '0;
    nib   = '0;
    seen  = 1'b0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      nib      = conv_bcd[4*i +: 4];
      seen     = seen | (nib != 4'd0) | (i == 0);
      glyph[i] = (BLANK_LEADING && !seen) ? SEG_BLANK : bcd_to_seg7(nib);
    end
  end

  // Next-state and datapath control for accept / convert / encode / commit.
  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    clamp_d      = clamp_q;
    ovf_d        = ovf_q;
    shadow_d     = shadow_q;
    shadow_neg_d = shadow_neg_q;
    dig_d        = dig_q;
    neg_d        = neg_q;
    update_ack   = 1'b0;
    conv_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (update_req) begin
          update_ack = resetn;
          conv_start = 1'b1;
          sign_d     = value[VALUE_W-1];
          clamp_d    = over_sat;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        shadow_d     = glyph;
        shadow_neg_d = sign_q ? SEG_MINUS : SEG_BLANK;
        state_d      = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          dig_d   = shadow_q;
          neg_d   = shadow_neg_q;
          ovf_d   = clamp_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow and displayed registers; reset shows a lone '0'.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      sign_q       <= 1'b0;
      clamp_q      <= 1'b0;
      ovf_q        <= 1'b0;
      shadow_q     <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
      shadow_neg_q <= SEG_BLANK;
      dig_q        <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
      neg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      clamp_q      <= clamp_d;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      shadow_neg_q <= shadow_neg_d;
      dig_q        <= dig_d;
      neg_q        <= neg_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign overflow      = ovf_q;
  assign seg7_dig0     = dig_q[0];
  assign seg7_dig1     = dig_q[1];
  assign seg7_dig2     = dig_q[2];
  assign seg7_dig3     = dig_q[3];
  assign seg7_dig4     = dig_q[4];
  assign seg7_neg_sign = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display_ctrl
// Description : Scoreboard bench for score_display_ctrl. Stimulus pushes the
//               expected display per update; a monitor pops and compares on
//               each commit (busy falling). A second instance shows all digits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_ctrl;

  typedef struct packed {
    logic [4:0][6:0] d;   // blanking instance, index 0 = ones digit
    logic [4:0][6:0] dn;  // non-blanking instance
    logic [6:0]      neg;
    logic            ovf;
    int              cyc; // cycle at which the new display must be visible
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [17:0] value = '0;
  logic        update_req = 1'b0;
  logic        frame_start = 1'b0;

  logic       update_ack, busy, overflow;
  logic [6:0] seg7_dig0, seg7_dig1, seg7_dig2, seg7_dig3, seg7_dig4, seg7_neg_sign;
  logic       nb_ack, nb_busy, nb_ovf;
  logic [6:0] nb_dig0, nb_dig1, nb_dig2, nb_dig3, nb_dig4, nb_neg;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [6:0] cur_dig0 = 7'h40;
  bit   prev_busy = 1'b0;

  score_display_ctrl #(.VALUE_W(18), .SAT_MAX(99999), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .resetn(resetn), .value(value), .update_req(update_req),
    .update_ack(update_ack), .frame_start(frame_start), .busy(busy),
    .overflow(overflow), .seg7_dig0(seg7_dig0), .seg7_dig1(seg7_dig1),
    .seg7_dig2(seg7_dig2), .seg7_dig3(seg7_dig3), .seg7_dig4(seg7_dig4),
    .seg7_neg_sign(seg7_neg_sign)
  );

  score_display_ctrl #(.VALUE_W(18), .SAT_MAX(99999), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .resetn(resetn), .value(value), .update_req(update_req),
    .update_ack(nb_ack), .frame_start(frame_start), .busy(nb_busy),
    .overflow(nb_ovf), .seg7_dig0(nb_dig0), .seg7_dig1(nb_dig1),
    .seg7_dig2(nb_dig2), .seg7_dig3(nb_dig3), .seg7_dig4(nb_dig4),
    .seg7_neg_sign(nb_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [34:0] d, input logic [34:0] dn,
                              input logic [6:0] neg, input logic ovf);
    exp_t e;
    e.d = d; e.dn = dn; e.neg = neg; e.ovf = ovf; e.cyc = 0;
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_dig"}, {seg7_dig4, seg7_dig3, seg7_dig2, seg7_dig1, seg7_dig0},
          {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check({tag, "_nb_dig"}, {nb_dig4, nb_dig3, nb_dig2, nb_dig1, nb_dig0},
          {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check({tag, "_neg"}, seg7_neg_sign, 7'h7F);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_ack"}, update_ack, 1'b0);
  endtask

  // One update: accept at cycle t0, frame_start at t0+frame_at, optional
  // ignored frame pulse at t0+early and ignored request poke at t0+3.
  task automatic do_update(input logic [17:0] v, input exp_t e, input int frame_at,
                           input int early, input bit poke);
    int t0;
    @(negedge clk);
    value = v; update_req = 1'b1; t0 = cyc;
    #1 check("ack_on_accept", update_ack, 1'b1);
    e.cyc = t0 + frame_at + 1;
    sb.push_back(e);
    for (int c = t0 + 1; c <= t0 + frame_at + 1; c++) begin
      @(negedge clk);
      if (c == t0 + 1) check("busy_after_accept", busy, 1'b1);
      if (c == t0 + frame_at) begin
        check("hold_before_commit", seg7_dig0, cur_dig0);
        check("busy_before_commit", busy, 1'b1);
      end
      update_req  = poke && (c == t0 + 3);
      value       = ~v;  // changes after accept must not matter
      frame_start = (c == t0 + frame_at) || (early != 0 && c == t0 + early);
      if (poke && c == t0 + 3) #1 check("no_ack_while_busy", update_ack, 1'b0);
    end
    update_req = 1'b0; frame_start = 1'b0;
  endtask

  // Monitor: a falling busy edge outside reset is a commit.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) prev_busy = 1'b0;
      else begin
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit: got commit expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("commit_cycle", cyc, e.cyc);
            check("dig", {seg7_dig4, seg7_dig3, seg7_dig2, seg7_dig1, seg7_dig0}, e.d);
            check("nb_dig", {nb_dig4, nb_dig3, nb_dig2, nb_dig1, nb_dig0}, e.dn);
            check("neg", seg7_neg_sign, e.neg);
            check("nb_neg", nb_neg, e.neg);
            check("ovf", overflow, e.ovf);
            check("nb_ovf", nb_ovf, e.ovf);
            cur_dig0 = seg7_dig0;
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check_reset("rst_held");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_reset("rst_idle");

    do_update(18'd12345, mk({7'h79,7'h24,7'h30,7'h19,7'h12}, {7'h79,7'h24,7'h30,7'h19,7'h12}, 7'h7F, 1'b0), 30, 0, 1'b0);
    do_update(18'h3FFD6, mk({7'h7F,7'h7F,7'h7F,7'h19,7'h24}, {7'h40,7'h40,7'h40,7'h19,7'h24}, 7'h3F, 1'b0), 25, 0, 1'b0);
    do_update(18'h1FFFF, mk({5{7'h10}}, {5{7'h10}}, 7'h7F, 1'b1), 20, 0, 1'b0);
    do_update(18'h20000, mk({5{7'h10}}, {5{7'h10}}, 7'h3F, 1'b1), 19, 0, 1'b0);
    do_update(18'd7,     mk({7'h7F,7'h7F,7'h7F,7'h7F,7'h78}, {7'h40,7'h40,7'h40,7'h40,7'h78}, 7'h7F, 1'b0), 22, 0, 1'b0);
    do_update(18'd99999, mk({5{7'h10}}, {5{7'h10}}, 7'h7F, 1'b0), 19, 0, 1'b0);
    do_update(18'h27960, mk({5{7'h10}}, {5{7'h10}}, 7'h3F, 1'b1), 21, 0, 1'b0);
    do_update(18'd1000,  mk({7'h7F,7'h79,7'h40,7'h40,7'h40}, {7'h40,7'h79,7'h40,7'h40,7'h40}, 7'h7F, 1'b0), 19, 5, 1'b1);

    // Reset while 54321 waits for a frame: it must never reach the display.
    @(negedge clk);
    value = 18'd54321; update_req = 1'b1;
    #1 check("ack_54321", update_ack, 1'b1);
    @(negedge clk);
    update_req = 1'b0;
    repeat (21) @(negedge clk);
    check("busy_in_wait_frame", busy, 1'b1);
    #2 resetn = 1'b0; update_req = 1'b1; frame_start = 1'b1;
    #1 check_reset("rst_async");
    repeat (2) @(negedge clk);
    update_req = 1'b0; frame_start = 1'b0; resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst_after");
    cur_dig0 = 7'h40;

    do_update(18'd0, mk({7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, {5{7'h40}}, 7'h7F, 1'b0), 19, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
